fifo_sync_param: RTL

//  Parametrised synchronous FIFO, next generation of the team's single-clock FIFO. Adds:

---
 rtl/fifo_sync_param_if.sv | 37 +++
 rtl/fifo_sync_param.sv | 112 +++++++++++
 2 files changed

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param. The FIFO takes the slave
// modport; the environment that drives requests takes the master modport.
interface fifo_sync_param_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  ovf_sticky;
  logic                  udf_sticky;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           ovf_sticky, udf_sticky, full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           ovf_sticky, udf_sticky, full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through reads and sticky error flags.
module fifo_sync_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter bit FWFT       = 1'b0
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_param_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  ovf_sticky;
  logic                  udf_sticky;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign wr_ok = bus.wr_en && !full;
  assign rd_ok = bus.rd_en && !empty;

  // Pointers wrap at FIFO_DEPTH-1 explicitly so any depth works; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
    end
  end

  // Storage array; contents are not reset, validity comes from count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.data_in;
  end

  // Per-cycle handshake/error pulses and sticky error flags (new error beats clr_err).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      wr_ack     <= wr_ok;
      overflow   <= bus.wr_en && full;
      underflow  <= bus.rd_en && empty;
      if (bus.wr_en && full) ovf_sticky <= 1'b1;
      else if (bus.clr_err)  ovf_sticky <= 1'b0;
      if (bus.rd_en && empty) udf_sticky <= 1'b1;
      else if (bus.clr_err)   udf_sticky <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so the
      // output is defined (and zero) straight out of reset.
      assign bus.data_out = empty ? '0 : mem[rd_ptr];
      assign bus.rd_valid = !empty;
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q;
      logic                  valid_q;

      // Registered read port: one-cycle latency, data held between reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (rd_ok) dout_q <= mem[rd_ptr];
        end
      end

      assign bus.data_out = dout_q;
      assign bus.rd_valid = valid_q;
    end
  endgenerate

  assign bus.wr_ack      = wr_ack;
  assign bus.overflow    = overflow;
  assign bus.underflow   = underflow;
  assign bus.ovf_sticky  = ovf_sticky;
  assign bus.udf_sticky  = udf_sticky;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = !full && (int'(count) >= AF_THRESH);
  assign bus.almostempty = !empty && (int'(count) <= AE_THRESH);
  assign bus.count       = count;
endmodule
